// File: rtl/rrf_alloc_pkg.sv
// Shared constants and helpers for the rename-register allocator.
// Sizes default to the RRF/ROB configuration used across dispatch.
package rrf_alloc_pkg;

   localparam int RRF_NUM_DEF = 64;
   localparam int RRF_SEL_DEF = 6;
   localparam int DP_WIDTH    = 2;

   // A request of 3 cannot be honoured by a 2-wide dispatch; treat it as 2.
   function automatic logic [1:0] clamp_req(input logic [1:0] req);
      return (req == 2'd3) ? 2'd2 : req;
   endfunction

endpackage

// File: rtl/rrf_alloc.sv
// In-order RRF tag allocator: hands out up to two consecutive tags per cycle,
// reclaims retired entries and rewinds the allocation pointer on a mispredict.
module rrf_alloc
   import rrf_alloc_pkg::*;
#(
   parameter int RRF_NUM = RRF_NUM_DEF,
   parameter int RRF_SEL = RRF_SEL_DEF
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic [1:0]         req_num_i,
   input  logic               stall_i,
   input  logic [1:0]         com_num_i,
   input  logic               prmiss_i,
   input  logic [RRF_SEL-1:0] rollback_ptr_i,
   output logic               allocatable_o,
   output logic [RRF_SEL-1:0] rrftag0_o,
   output logic [RRF_SEL-1:0] rrftag1_o,
   output logic               alloc_en0_o,
   output logic               alloc_en1_o,
   output logic [RRF_SEL-1:0] rrfptr_o,
   output logic               nextrrfcyc_o,
   output logic [RRF_SEL:0]   freenum_o
);

   localparam logic [RRF_SEL:0] FULL_CNT = (RRF_SEL+1)'(RRF_NUM);

   logic [RRF_SEL-1:0] rrfptr;
   logic [RRF_SEL-1:0] comptr;
   logic [RRF_SEL:0]   freenum;
   logic               nextrrfcyc;

   logic [1:0]         req_eff;
   logic [RRF_SEL:0]   req_w;
   logic [RRF_SEL:0]   com_w;
   logic [RRF_SEL:0]   alloc_w;
   logic               fire;
   logic [RRF_SEL:0]   ptr_sum;
   logic [RRF_SEL-1:0] comptr_next;
   logic [RRF_SEL-1:0] roll_dist;
   logic [RRF_SEL:0]   inflight;
   logic [RRF_SEL:0]   inflight_after;

   // Handshake: a slot's tag is taken exactly when its alloc_en is high in a
   // cycle; with no enable the dispatcher must present the request again.
   // There is no partial grant and a flush always wins over allocation.
   always_comb begin
      req_eff        = clamp_req(req_num_i);
      req_w          = (RRF_SEL+1)'(req_eff);
      com_w          = (RRF_SEL+1)'(com_num_i);
      allocatable_o  = (freenum >= req_w);
      fire           = reset_ni & allocatable_o & ~stall_i & ~prmiss_i;
      alloc_w        = fire ? req_w : '0;
      alloc_en0_o    = fire & (req_eff != 2'd0);
      alloc_en1_o    = fire & (req_eff == 2'd2);
      // The carry out of the pointer add is the wrap event (RRF_NUM is 2**RRF_SEL).
      ptr_sum        = {1'b0, rrfptr} + alloc_w;
      comptr_next    = comptr + RRF_SEL'(com_num_i);
      roll_dist      = rollback_ptr_i - comptr_next;
      inflight       = FULL_CNT - freenum;
      inflight_after = inflight - com_w;
   end

   assign rrftag0_o    = rrfptr;
   assign rrftag1_o    = rrfptr + RRF_SEL'(1);
   assign rrfptr_o     = rrfptr;
   assign nextrrfcyc_o = nextrrfcyc;
   assign freenum_o    = freenum;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rrfptr     <= '0;
         comptr     <= '0;
         freenum    <= FULL_CNT;
         nextrrfcyc <= 1'b0;
      end else if (prmiss_i) begin
         rrfptr  <= rollback_ptr_i;
         comptr  <= comptr_next;
         freenum <= FULL_CNT - {1'b0, roll_dist};
         // Rolling back past index 0 returns to the previous wrap epoch.
         if (rollback_ptr_i > rrfptr) begin
            nextrrfcyc <= ~nextrrfcyc;
         end
      end else begin
         rrfptr     <= ptr_sum[RRF_SEL-1:0];
         nextrrfcyc <= nextrrfcyc ^ ptr_sum[RRF_SEL];
         comptr     <= comptr_next;
         freenum    <= freenum - alloc_w + com_w;
      end
   end

   a_retire_legal : assert property (@(posedge clk_i) disable iff (!reset_ni)
      com_w <= inflight);

   a_rollback_legal : assert property (@(posedge clk_i) disable iff (!reset_ni)
      prmiss_i |-> ((RRF_SEL+1)'(roll_dist) <= inflight_after));

endmodule

// File: tb/tb_rrf_alloc.sv
// Bench for rrf_alloc: table vectors, directed corner sequences and random
// traffic checked against a running-total model of allocations and retires.
module tb_rrf_alloc;

   localparam int N   = 64;
   localparam int SEL = 6;

   logic           clk_i = 1'b0;
   logic           reset_ni;
   logic [1:0]     req_num_i;
   logic           stall_i;
   logic [1:0]     com_num_i;
   logic           prmiss_i;
   logic [SEL-1:0] rollback_ptr_i;
   logic           allocatable_o;
   logic [SEL-1:0] rrftag0_o;
   logic [SEL-1:0] rrftag1_o;
   logic           alloc_en0_o;
   logic           alloc_en1_o;
   logic [SEL-1:0] rrfptr_o;
   logic           nextrrfcyc_o;
   logic [SEL:0]   freenum_o;

   rrf_alloc #(.RRF_NUM(N), .RRF_SEL(SEL)) dut (
      .clk_i          (clk_i),
      .reset_ni       (reset_ni),
      .req_num_i      (req_num_i),
      .stall_i        (stall_i),
      .com_num_i      (com_num_i),
      .prmiss_i       (prmiss_i),
      .rollback_ptr_i (rollback_ptr_i),
      .allocatable_o  (allocatable_o),
      .rrftag0_o      (rrftag0_o),
      .rrftag1_o      (rrftag1_o),
      .alloc_en0_o    (alloc_en0_o),
      .alloc_en1_o    (alloc_en1_o),
      .rrfptr_o       (rrfptr_o),
      .nextrrfcyc_o   (nextrrfcyc_o),
      .freenum_o      (freenum_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: unbounded counts of tags handed out and entries retired.
   int alloc_tot = 0;
   int ret_tot   = 0;

   logic           s_alloc, s_en0, s_en1;
   logic [SEL-1:0] s_tag0, s_tag1;

   typedef struct {
      logic [1:0] req;
      logic       stall;
      logic [1:0] com;
      logic       exp_alloc;
      logic       exp_en0;
      logic       exp_en1;
      int         exp_tag0;
      int         exp_ptr;
      int         exp_free;
   } vec_t;

   vec_t vecs[6];

   function automatic int m_free();
      return N - (alloc_tot - ret_tot);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      reset_ni       = 1'b0;
      req_num_i      = 2'd0;
      stall_i        = 1'b0;
      com_num_i      = 2'd0;
      prmiss_i       = 1'b0;
      rollback_ptr_i = '0;
      #12;
      @(negedge clk_i);
      reset_ni = 1'b1;
      @(posedge clk_i);
      #1;
      alloc_tot = 0;
      ret_tot   = 0;
   endtask

   // One cycle: drive, check combinational outputs at negedge, check state after posedge.
   task automatic step(input logic [1:0] req, input logic stall, input logic [1:0] com,
                       input logic prmiss, input logic [SEL-1:0] rb);
      int   r, rn, d;
      logic fire;
      req_num_i      = req;
      stall_i        = stall;
      com_num_i      = com;
      prmiss_i       = prmiss;
      rollback_ptr_i = rb;
      r    = (req == 2'd3) ? 2 : int'(req);
      fire = (m_free() >= r) && !stall && !prmiss;
      @(negedge clk_i);
      s_alloc = allocatable_o;
      s_en0   = alloc_en0_o;
      s_en1   = alloc_en1_o;
      s_tag0  = rrftag0_o;
      s_tag1  = rrftag1_o;
      chk("allocatable", int'(s_alloc), int'(m_free() >= r));
      chk("alloc_en0", int'(s_en0), int'(fire && r >= 1));
      chk("alloc_en1", int'(s_en1), int'(fire && r == 2));
      chk("rrftag0", int'(s_tag0), alloc_tot % N);
      chk("rrftag1", int'(s_tag1), (alloc_tot + 1) % N);
      @(posedge clk_i);
      #1;
      rn = ret_tot + int'(com);
      if (prmiss) begin
         d = (int'(rb) - (rn % N) + N) % N;
         alloc_tot = rn + d;
      end else if (fire) begin
         alloc_tot += r;
      end
      ret_tot = rn;
      chk("rrfptr", int'(rrfptr_o), alloc_tot % N);
      chk("freenum", int'(freenum_o), m_free());
      chk("nextrrfcyc", int'(nextrrfcyc_o), (alloc_tot / N) % 2);
   endtask

   initial begin
      vecs[0] = '{2'd2, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 0, 2, 62};
      vecs[1] = '{2'd1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2, 2, 62};
      vecs[2] = '{2'd3, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 2, 4, 60};
      vecs[3] = '{2'd0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 4, 4, 62};
      vecs[4] = '{2'd1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 4, 5, 62};
      vecs[5] = '{2'd2, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 5, 7, 61};

      do_reset();
      chk("reset_rrfptr", int'(rrfptr_o), 0);
      chk("reset_freenum", int'(freenum_o), N);
      chk("reset_nextrrfcyc", int'(nextrrfcyc_o), 0);
      chk("reset_allocatable", int'(allocatable_o), 1);
      chk("reset_en0", int'(alloc_en0_o), 0);
      chk("reset_en1", int'(alloc_en1_o), 0);
      chk("reset_tag0", int'(rrftag0_o), 0);
      chk("reset_tag1", int'(rrftag1_o), 1);

      for (int i = 0; i < 6; i++) begin
         step(vecs[i].req, vecs[i].stall, vecs[i].com, 1'b0, '0);
         chk("vec_allocatable", int'(s_alloc), int'(vecs[i].exp_alloc));
         chk("vec_en0", int'(s_en0), int'(vecs[i].exp_en0));
         chk("vec_en1", int'(s_en1), int'(vecs[i].exp_en1));
         chk("vec_tag0", int'(s_tag0), vecs[i].exp_tag0);
         chk("vec_rrfptr", int'(rrfptr_o), vecs[i].exp_ptr);
         chk("vec_freenum", int'(freenum_o), vecs[i].exp_free);
      end

      // Drain from reset, then the full boundary.
      do_reset();
      for (int i = 0; i < 32; i++) begin
         step(2'd2, 1'b0, 2'd0, 1'b0, '0);
         chk("drain_tag0", int'(s_tag0), 2 * i);
         chk("drain_tag1", int'(s_tag1), 2 * i + 1);
      end
      chk("drain_freenum", int'(freenum_o), 0);
      step(2'd1, 1'b1, 2'd0, 1'b0, '0);
      chk("full_req1_allocatable", int'(s_alloc), 0);
      step(2'd2, 1'b1, 2'd0, 1'b0, '0);
      chk("full_req2_allocatable", int'(s_alloc), 0);
      step(2'd0, 1'b0, 2'd1, 1'b0, '0);
      chk("full_req0_allocatable", int'(s_alloc), 1);
      chk("full_retire_freenum", int'(freenum_o), 1);
      step(2'd2, 1'b0, 2'd0, 1'b0, '0);
      chk("one_free_req2_en0", int'(s_en0), 0);
      chk("one_free_req2_en1", int'(s_en1), 0);
      step(2'd1, 1'b0, 2'd0, 1'b0, '0);
      chk("one_free_req1_en0", int'(s_en0), 1);
      chk("one_free_req1_tag0", int'(s_tag0), 0);
      chk("one_free_req1_freenum", int'(freenum_o), 0);

      // Wrap with 10 free, then concurrent allocate and retire with 5 free.
      do_reset();
      for (int i = 0; i < 27; i++) step(2'd2, 1'b0, 2'd0, 1'b0, '0);
      for (int i = 0; i < 4; i++) step(2'd2, 1'b0, 2'd2, 1'b0, '0);
      step(2'd1, 1'b0, 2'd1, 1'b0, '0);
      chk("prewrap_rrfptr", int'(rrfptr_o), 63);
      chk("prewrap_freenum", int'(freenum_o), 10);
      step(2'd2, 1'b0, 2'd0, 1'b0, '0);
      chk("wrap_tag0", int'(s_tag0), 63);
      chk("wrap_tag1", int'(s_tag1), 0);
      chk("wrap_rrfptr", int'(rrfptr_o), 1);
      chk("wrap_nextrrfcyc", int'(nextrrfcyc_o), 1);
      for (int i = 0; i < 3; i++) step(2'd1, 1'b0, 2'd0, 1'b0, '0);
      chk("preconc_freenum", int'(freenum_o), 5);
      step(2'd2, 1'b0, 2'd2, 1'b0, '0);
      chk("conc_freenum", int'(freenum_o), 5);
      chk("conc_rrfptr", int'(rrfptr_o), 6);

      // Flush with a simultaneous request and retire.
      do_reset();
      for (int i = 0; i < 10; i++) step(2'd2, 1'b0, 2'd0, 1'b0, '0);
      step(2'd0, 1'b0, 2'd2, 1'b0, '0);
      step(2'd0, 1'b0, 2'd2, 1'b0, '0);
      step(2'd2, 1'b0, 2'd1, 1'b1, 6'd10);
      chk("flush_en0", int'(s_en0), 0);
      chk("flush_en1", int'(s_en1), 0);
      chk("flush_rrfptr", int'(rrfptr_o), 10);
      chk("flush_freenum", int'(freenum_o), 59);
      chk("flush_nextrrfcyc", int'(nextrrfcyc_o), 0);

      // Asynchronous reset in the middle of an allocating cycle.
      do_reset();
      for (int i = 0; i < 3; i++) step(2'd2, 1'b0, 2'd0, 1'b0, '0);
      req_num_i = 2'd2;
      stall_i   = 1'b0;
      com_num_i = 2'd0;
      prmiss_i  = 1'b0;
      @(posedge clk_i);
      #3;
      reset_ni = 1'b0;
      #1;
      chk("async_rrfptr", int'(rrfptr_o), 0);
      chk("async_freenum", int'(freenum_o), N);
      chk("async_tag0", int'(rrftag0_o), 0);
      chk("async_tag1", int'(rrftag1_o), 1);
      chk("async_nextrrfcyc", int'(nextrrfcyc_o), 0);
      chk("async_en0", int'(alloc_en0_o), 0);
      chk("async_en1", int'(alloc_en1_o), 0);

      // Random legal traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int         infl, cmax, ia, dmax, d;
         logic [1:0] req, com;
         logic       stall, pm;
         logic [SEL-1:0] rb;
         infl  = alloc_tot - ret_tot;
         cmax  = (infl < 2) ? infl : 2;
         com   = 2'($urandom_range(0, cmax));
         req   = 2'($urandom_range(0, 3));
         stall = ($urandom_range(0, 4) == 0);
         pm    = ($urandom_range(0, 19) == 0);
         rb    = '0;
         if (pm) begin
            ia   = infl - int'(com);
            dmax = (ia < N - 1) ? ia : N - 1;
            d    = int'($urandom_range(0, dmax));
            rb   = SEL'((ret_tot + int'(com) + d) % N);
         end
         step(req, stall, com, pm, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
